// File: rtl/quad_adc_sample_packer_pkg.sv
// Shared constants, FSM state type and ADC-word conversion for the quad ADC sample packer.
package quad_adc_pkg;
  localparam int ADC_BITS       = 14;
  localparam int LANE_BITS      = 16;
  localparam int NUM_CH         = 4;
  localparam int FMT_OFFSET_BIN = 0;
  localparam int FMT_TWOS       = 1;

  typedef enum logic {ST_IDLE, ST_CAPTURE} pack_state_e;

  // Offset binary is two's complement with the MSB inverted; both then sign-extend.
  function automatic logic [LANE_BITS-1:0] adc_to_lane(input logic [ADC_BITS-1:0] d,
                                                       input logic offset_bin);
    logic [ADC_BITS-1:0] s;
    s = offset_bin ? {~d[ADC_BITS-1], d[ADC_BITS-2:0]} : d;
    return {{(LANE_BITS-ADC_BITS){s[ADC_BITS-1]}}, s};
  endfunction
endpackage

// File: rtl/quad_adc_sample_packer_if.sv
// AXI-Stream beat interface carrying one packed four-channel sample set per beat.
interface quad_adc_sample_packer_if;
  import quad_adc_pkg::*;
  logic [NUM_CH*LANE_BITS-1:0] TDATA;
  logic                        TVALID;
  logic                        TREADY;
  logic                        TLAST;

  modport master (output TDATA, TVALID, TLAST, input TREADY);
  modport slave  (input TDATA, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/quad_adc_sample_packer_fifo.sv
// Show-ahead synchronous FIFO with registered occupancy; a same-cycle read never frees a slot for a write.
module sample_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_acc, rd_acc;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CW'(DEPTH));
  assign wr_acc    = wr_en_i & ~full_o;
  assign rd_acc    = rd_en_i & ~empty_o;
  // Output is forced to zero while empty so the bus idles at a known value.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/quad_adc_sample_packer.sv
// Converts four ADC channel words to 16-bit lanes, frames them into fixed-length AXI-Stream packets.
module quad_adc_sample_packer
  import quad_adc_pkg::*;
#(
  parameter int DATA_FORMAT    = FMT_OFFSET_BIN,
  parameter int PACKET_SAMPLES = 256,
  parameter int FIFO_DEPTH     = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic                  SAMPLE_VALID,
  input  logic [ADC_BITS-1:0]   CH_A_DATA,
  input  logic [ADC_BITS-1:0]   CH_B_DATA,
  input  logic [ADC_BITS-1:0]   CH_C_DATA,
  input  logic [ADC_BITS-1:0]   CH_D_DATA,
  input  logic                  CLEAR_OVERFLOW,
  quad_adc_sample_packer_if.master M_AXIS,
  output logic                  BUSY,
  output logic                  OVERFLOW,
  output logic [15:0]           OVERFLOW_COUNT
);
  localparam int          BEAT_W   = NUM_CH * LANE_BITS;
  localparam logic [15:0] LAST_IDX = 16'(PACKET_SAMPLES - 1);

  pack_state_e                      state_q, state_d;
  logic [NUM_CH-1:0][ADC_BITS-1:0]  raw;
  logic [NUM_CH-1:0][LANE_BITS-1:0] lane, conv_q;
  logic                             conv_vld_q, accept;
  logic                             fifo_full, fifo_empty, wr_ok, drop, is_last, last_wr;
  logic [15:0]                      beat_cnt_q, beat_cnt_d, ovf_cnt_q, ovf_cnt_d;
  logic                             ovf_q, ovf_d;
  logic [BEAT_W:0]                  fifo_dout;

  assign raw = {CH_D_DATA, CH_C_DATA, CH_B_DATA, CH_A_DATA};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    assign lane[ch] = adc_to_lane(raw[ch], DATA_FORMAT == FMT_OFFSET_BIN);
  end

  assign wr_ok   = conv_vld_q & ~fifo_full;
  assign drop    = conv_vld_q & fifo_full;
  assign is_last = (beat_cnt_q == LAST_IDX);
  assign last_wr = wr_ok & is_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (ENABLE) state_d = ST_CAPTURE;
      ST_CAPTURE: if (last_wr && !ENABLE) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A strobe on the cycle the packet closes would open a packet that never finishes.
  assign accept = SAMPLE_VALID && (state_q == ST_CAPTURE) && (state_d == ST_CAPTURE);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (wr_ok) beat_cnt_d = is_last ? '0 : beat_cnt_q + 16'd1;
    ovf_d     = ovf_q;
    ovf_cnt_d = ovf_cnt_q;
    if (CLEAR_OVERFLOW) begin
      ovf_d     = drop;
      ovf_cnt_d = {15'd0, drop};
    end else if (drop) begin
      ovf_d = 1'b1;
      if (ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      conv_q     <= '0;
      conv_vld_q <= 1'b0;
      beat_cnt_q <= '0;
      ovf_q      <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      conv_vld_q <= accept;
      if (accept) conv_q <= lane;
      beat_cnt_q <= beat_cnt_d;
      ovf_q      <= ovf_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  sample_fifo #(
    .WIDTH (BEAT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .wr_en_i   (conv_vld_q),
    .wr_data_i ({is_last, conv_q}),
    .rd_en_i   (M_AXIS.TREADY),
    .rd_data_o (fifo_dout),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign M_AXIS.TVALID  = ~fifo_empty;
  assign M_AXIS.TLAST   = fifo_dout[BEAT_W];
  assign M_AXIS.TDATA   = fifo_dout[BEAT_W-1:0];
  assign BUSY           = (state_q == ST_CAPTURE);
  assign OVERFLOW       = ovf_q;
  assign OVERFLOW_COUNT = ovf_cnt_q;
endmodule

// File: tb/tb_quad_adc_sample_packer.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares accepted beats.
module tb_quad_adc_sample_packer;
  logic        CLK = 1'b0;
  logic        RST, ENABLE, SAMPLE_VALID, CLEAR_OVERFLOW;
  logic [13:0] cha, chb, chc, chd;
  logic        BUSY, OVERFLOW;
  logic [15:0] OVERFLOW_COUNT;

  quad_adc_sample_packer_if m_axis ();

  quad_adc_sample_packer #(
    .DATA_FORMAT    (0),
    .PACKET_SAMPLES (4),
    .FIFO_DEPTH     (4)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ENABLE         (ENABLE),
    .SAMPLE_VALID   (SAMPLE_VALID),
    .CH_A_DATA      (cha),
    .CH_B_DATA      (chb),
    .CH_C_DATA      (chc),
    .CH_D_DATA      (chd),
    .CLEAR_OVERFLOW (CLEAR_OVERFLOW),
    .M_AXIS         (m_axis),
    .BUSY           (BUSY),
    .OVERFLOW       (OVERFLOW),
    .OVERFLOW_COUNT (OVERFLOW_COUNT)
  );

  always #5 CLK = ~CLK;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [64:0] exp_q [$];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat is compared; a stalled beat must not change.
  logic        stall_q = 1'b0;
  logic [64:0] held_q  = '0;
  logic [64:0] exp_beat;
  always @(negedge CLK) begin
    if (RST) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", {64'd0, m_axis.TVALID}, 65'd1);
        check("hold_beat", {m_axis.TLAST, m_axis.TDATA}, held_q);
      end
      if (m_axis.TVALID && m_axis.TREADY) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat: got unexpected beat %h, expected none", {m_axis.TLAST, m_axis.TDATA});
        end else begin
          exp_beat = exp_q.pop_front();
          check("beat", {m_axis.TLAST, m_axis.TDATA}, exp_beat);
        end
      end
      stall_q <= m_axis.TVALID & ~m_axis.TREADY;
      held_q  <= {m_axis.TLAST, m_axis.TDATA};
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic strobe(input logic [13:0] a, input logic [13:0] b,
                        input logic [13:0] c, input logic [13:0] d);
    SAMPLE_VALID = 1'b1;
    cha = a; chb = b; chc = c; chd = d;
    tick();
    SAMPLE_VALID = 1'b0;
  endtask

  // Offset-binary 14'h2000+v converts to lane value v on every channel.
  task automatic sbeat(input int v, input bit last);
    exp_q.push_back({last, {4{16'(v)}}});
    strobe(14'(14'h2000 + v), 14'(14'h2000 + v), 14'(14'h2000 + v), 14'(14'h2000 + v));
  endtask

  task automatic strobe_raw(input int v);
    strobe(14'(v), 14'(v + 1), 14'(v + 2), 14'(v + 3));
  endtask

  initial begin
    RST = 1'b1; ENABLE = 1'b0; SAMPLE_VALID = 1'b0; CLEAR_OVERFLOW = 1'b0;
    cha = '0; chb = '0; chc = '0; chd = '0;
    m_axis.TREADY = 1'b1;
    idle(2);
    check("rst_tvalid", {64'd0, m_axis.TVALID}, 65'd0);
    check("rst_tlast", {64'd0, m_axis.TLAST}, 65'd0);
    check("rst_tdata", {1'b0, m_axis.TDATA}, 65'd0);
    check("rst_busy", {64'd0, BUSY}, 65'd0);
    check("rst_ovf", {64'd0, OVERFLOW}, 65'd0);
    check("rst_ovf_cnt", {49'd0, OVERFLOW_COUNT}, 65'd0);
    RST = 1'b0;

    // Strobe in IDLE is ignored
    strobe_raw(14'h100);
    idle(2);
    check("idle_ignore", {64'd0, m_axis.TVALID}, 65'd0);

    // Conversion and latency; 2AAA is +0AAA in offset binary, 0000 is -2000
    ENABLE = 1'b1;
    tick();
    check("busy_capture", {64'd0, BUSY}, 65'd1);
    exp_q.push_back({1'b0, 64'h0000_1FFF_E000_0AAA});
    strobe(14'h2AAA, 14'h0000, 14'h3FFF, 14'h2000);
    check("lat_n1", {64'd0, m_axis.TVALID}, 65'd0);
    tick();
    check("lat_n2", {64'd0, m_axis.TVALID}, 65'd1);
    sbeat(1, 1'b0); sbeat(2, 1'b0); sbeat(3, 1'b1);
    idle(3);

    // Framing: 8 back-to-back strobes, TLAST on 4 and 8
    for (int i = 1; i <= 8; i++) sbeat(16 + i, (i % 4) == 0);
    idle(4);

    // ENABLE drop mid-packet
    sbeat(30, 1'b0); sbeat(31, 1'b0);
    ENABLE = 1'b0;
    sbeat(32, 1'b0); sbeat(33, 1'b1);
    strobe_raw(14'h200); strobe_raw(14'h300);
    idle(3);
    check("drop_busy", {64'd0, BUSY}, 65'd0);

    // Overflow: 4 buffered, 2 dropped
    m_axis.TREADY = 1'b0;
    ENABLE = 1'b1;
    tick();
    sbeat(40, 1'b0); sbeat(41, 1'b0); sbeat(42, 1'b0); sbeat(43, 1'b1);
    strobe_raw(14'h400); strobe_raw(14'h500);
    idle(2);
    check("ovf_flag", {64'd0, OVERFLOW}, 65'd1);
    check("ovf_cnt", {49'd0, OVERFLOW_COUNT}, 65'd2);
    check("ovf_tvalid", {64'd0, m_axis.TVALID}, 65'd1);
    m_axis.TREADY = 1'b1;
    idle(8);
    check("ovf_drained", 65'(exp_q.size()), 65'd0);
    CLEAR_OVERFLOW = 1'b1;
    tick();
    CLEAR_OVERFLOW = 1'b0;
    check("clr_flag", {64'd0, OVERFLOW}, 65'd0);
    check("clr_cnt", {49'd0, OVERFLOW_COUNT}, 65'd0);

    // Reset after 2 of 4 beats
    m_axis.TREADY = 1'b0;
    strobe_raw(14'h600); strobe_raw(14'h700);
    idle(2);
    check("pre_rst_tvalid", {64'd0, m_axis.TVALID}, 65'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("post_rst_tvalid", {64'd0, m_axis.TVALID}, 65'd0);
    check("post_rst_busy", {64'd0, BUSY}, 65'd0);
    m_axis.TREADY = 1'b1;
    tick();
    check("post_rst_capture", {64'd0, BUSY}, 65'd1);
    sbeat(50, 1'b0); sbeat(51, 1'b0); sbeat(52, 1'b0); sbeat(53, 1'b1);
    idle(4);

    // Clear and drop in the same cycle: count restarts at 1
    m_axis.TREADY = 1'b0;
    sbeat(60, 1'b0); sbeat(61, 1'b0); sbeat(62, 1'b0); sbeat(63, 1'b1);
    strobe_raw(14'h800); strobe_raw(14'h900);
    CLEAR_OVERFLOW = 1'b1;
    tick();
    CLEAR_OVERFLOW = 1'b0;
    check("clr_drop_flag", {64'd0, OVERFLOW}, 65'd1);
    check("clr_drop_cnt", {49'd0, OVERFLOW_COUNT}, 65'd1);
    m_axis.TREADY = 1'b1;
    idle(8);
    CLEAR_OVERFLOW = 1'b1;
    tick();
    CLEAR_OVERFLOW = 1'b0;

    // Backpressure: TREADY toggles while strobing continuously
    for (int i = 0; i < 6; i++) begin
      m_axis.TREADY = (i % 2) == 1;
      sbeat(70 + i, i == 3);
    end
    for (int j = 0; j < 12; j++) begin
      m_axis.TREADY = (j % 2) == 0;
      tick();
    end
    m_axis.TREADY = 1'b1;
    idle(4);
    check("bp_no_loss", {64'd0, OVERFLOW}, 65'd0);

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
    check("final_queue_empty", 65'(exp_q.size()), 65'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
